// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the register-transfer datapath.
// Every strobe is registered and is computed from the next state. The outputs therefore
// change together with the state register and always match the current state.
module control_sequencer #(
  parameter int unsigned OPCODE_W    = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clock_i,
  input  logic                clear_i,
  input  logic                run_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ack_i,
  output logic                pco_o,
  output logic                mari_o,
  output logic                incpc_o,
  output logic                zi_o,
  output logic                zlo_o,
  output logic                pci_o,
  output logic                read_o,
  output logic                mdri_o,
  output logic                mdro_o,
  output logic                iri_o,
  output logic                gra_o,
  output logic                grb_o,
  output logic                grc_o,
  output logic                rin_o,
  output logic                rout_o,
  output logic                ryi_o,
  output logic [OPCODE_W-1:0] alu_op_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic                fault_o
);

  typedef enum logic [3:0] {
    StIdle, StF0, StF1, StF2, StDec, StT3, StT4, StT5, StHalted, StFault
  } state_e;

  typedef struct packed {
    logic                pco;
    logic                mari;
    logic                incpc;
    logic                zi;
    logic                zlo;
    logic                pci;
    logic                read;
    logic                mdri;
    logic                mdro;
    logic                iri;
    logic                gra;
    logic                grb;
    logic                grc;
    logic                rin;
    logic                rout;
    logic                ryi;
    logic [OPCODE_W-1:0] alu_op;
    logic                busy;
    logic                halted;
    logic                fault;
  } ctrl_t;

  localparam logic [7:0]          TimeoutCnt = 8'(MEM_TIMEOUT);
  localparam logic [OPCODE_W-1:0] OpcAluMax  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OpcNop     = OPCODE_W'(24);
  localparam logic [OPCODE_W-1:0] OpcHalt    = OPCODE_W'(27);

  state_e              state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  ctrl_t               ctrl_q, ctrl_d;

  // Next-state logic: sequencing, the memory wait counter and the opcode latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    opc_d   = opc_q;
    unique case (state_q)
      StIdle: if (run_i) state_d = StF0;
      StF0: begin
        state_d = StF1;
        wait_d  = '0;
      end
      StF1: begin
        if (mem_ack_i) begin
          state_d = StF2;
          wait_d  = '0;
        end else if (wait_q == TimeoutCnt) begin
          state_d = StFault;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StF2: state_d = StDec;
      StDec: begin
        opc_d = opcode_i;
        if (opcode_i <= OpcAluMax)   state_d = StT3;
        else if (opcode_i == OpcNop) state_d = run_i ? StF0 : StIdle;
        else if (opcode_i == OpcHalt) state_d = StHalted;
        else                          state_d = StFault;
      end
      StT3: state_d = StT4;
      StT4: state_d = StT5;
      StT5: state_d = run_i ? StF0 : StIdle;
      StHalted, StFault: state_d = state_q;
      default: state_d = StIdle;
    endcase
  end

  // Strobe decode for the state being entered. PC is loaded only on the cycle that enters F1.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      StF0: begin
        ctrl_d.pco   = 1'b1;
        ctrl_d.mari  = 1'b1;
        ctrl_d.incpc = 1'b1;
        ctrl_d.zi    = 1'b1;
        ctrl_d.busy  = 1'b1;
      end
      StF1: begin
        ctrl_d.zlo  = 1'b1;
        ctrl_d.pci  = (state_q == StF0);
        ctrl_d.read = 1'b1;
        ctrl_d.mdri = 1'b1;
        ctrl_d.busy = 1'b1;
      end
      StF2: begin
        ctrl_d.mdro = 1'b1;
        ctrl_d.iri  = 1'b1;
        ctrl_d.busy = 1'b1;
      end
      StDec: ctrl_d.busy = 1'b1;
      StT3: begin
        ctrl_d.grb  = 1'b1;
        ctrl_d.rout = 1'b1;
        ctrl_d.ryi  = 1'b1;
        ctrl_d.busy = 1'b1;
      end
      StT4: begin
        ctrl_d.grc    = 1'b1;
        ctrl_d.rout   = 1'b1;
        ctrl_d.zi     = 1'b1;
        ctrl_d.alu_op = opc_d;
        ctrl_d.busy   = 1'b1;
      end
      StT5: begin
        ctrl_d.zlo  = 1'b1;
        ctrl_d.gra  = 1'b1;
        ctrl_d.rin  = 1'b1;
        ctrl_d.busy = 1'b1;
      end
      StHalted: ctrl_d.halted = 1'b1;
      StFault:  ctrl_d.fault  = 1'b1;
      default:  ctrl_d = '0;
    endcase
  end

  // State, counter, opcode latch and output registers; clear overrides everything.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q <= StIdle;
      wait_q  <= '0;
      opc_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      opc_q   <= opc_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign pco_o    = ctrl_q.pco;
  assign mari_o   = ctrl_q.mari;
  assign incpc_o  = ctrl_q.incpc;
  assign zi_o     = ctrl_q.zi;
  assign zlo_o    = ctrl_q.zlo;
  assign pci_o    = ctrl_q.pci;
  assign read_o   = ctrl_q.read;
  assign mdri_o   = ctrl_q.mdri;
  assign mdro_o   = ctrl_q.mdro;
  assign iri_o    = ctrl_q.iri;
  assign gra_o    = ctrl_q.gra;
  assign grb_o    = ctrl_q.grb;
  assign grc_o    = ctrl_q.grc;
  assign rin_o    = ctrl_q.rin;
  assign rout_o   = ctrl_q.rout;
  assign ryi_o    = ctrl_q.ryi;
  assign alu_op_o = ctrl_q.alu_op;
  assign busy_o   = ctrl_q.busy;
  assign halted_o = ctrl_q.halted;
  assign fault_o  = ctrl_q.fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected strobe words are queued as stimulus is driven
// and checked on the following falling edge.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clear, run, mem_ack;
  logic [4:0] opcode;
  logic pco, mari, incpc, zi, zlo, pci, read, mdri, mdro, iri;
  logic gra, grb, grc, rin, rout, ryi, busy, halted, fault;
  logic [4:0] alu_op;

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_W(5), .MEM_TIMEOUT(15)) dut (
    .clock_i(clk), .clear_i(clear), .run_i(run), .opcode_i(opcode), .mem_ack_i(mem_ack),
    .pco_o(pco), .mari_o(mari), .incpc_o(incpc), .zi_o(zi), .zlo_o(zlo), .pci_o(pci),
    .read_o(read), .mdri_o(mdri), .mdro_o(mdro), .iri_o(iri), .gra_o(gra), .grb_o(grb),
    .grc_o(grc), .rin_o(rin), .rout_o(rout), .ryi_o(ryi), .alu_op_o(alu_op), .busy_o(busy),
    .halted_o(halted), .fault_o(fault)
  );

  // Observed word: alu_op in [23:19], then one bit per strobe/status down to fault in [0].
  logic [23:0] obs;
  assign obs = {alu_op, pco, mari, incpc, zi, zlo, pci, read, mdri, mdro, iri,
                gra, grb, grc, rin, rout, ryi, busy, halted, fault};

  localparam logic [23:0] B_PCO = 24'd1 << 18, B_MARI = 24'd1 << 17, B_INCPC = 24'd1 << 16;
  localparam logic [23:0] B_ZI = 24'd1 << 15, B_ZLO = 24'd1 << 14, B_PCI = 24'd1 << 13;
  localparam logic [23:0] B_READ = 24'd1 << 12, B_MDRI = 24'd1 << 11, B_MDRO = 24'd1 << 10;
  localparam logic [23:0] B_IRI = 24'd1 << 9, B_GRA = 24'd1 << 8, B_GRB = 24'd1 << 7;
  localparam logic [23:0] B_GRC = 24'd1 << 6, B_RIN = 24'd1 << 5, B_ROUT = 24'd1 << 4;
  localparam logic [23:0] B_RYI = 24'd1 << 3, B_BUSY = 24'd1 << 2, B_HALT = 24'd1 << 1;
  localparam logic [23:0] B_FAULT = 24'd1;

  localparam logic [23:0] E_IDLE  = 24'd0;
  localparam logic [23:0] E_F0    = B_PCO | B_MARI | B_INCPC | B_ZI | B_BUSY;
  localparam logic [23:0] E_F1F   = B_ZLO | B_PCI | B_READ | B_MDRI | B_BUSY;
  localparam logic [23:0] E_F1W   = B_ZLO | B_READ | B_MDRI | B_BUSY;
  localparam logic [23:0] E_F2    = B_MDRO | B_IRI | B_BUSY;
  localparam logic [23:0] E_DEC   = B_BUSY;
  localparam logic [23:0] E_T3    = B_GRB | B_ROUT | B_RYI | B_BUSY;
  localparam logic [23:0] E_T5    = B_ZLO | B_GRA | B_RIN | B_BUSY;
  localparam logic [23:0] E_HALT  = B_HALT;
  localparam logic [23:0] E_FAULT = B_FAULT;

  function automatic logic [23:0] e_t4(input logic [4:0] op);
    return B_GRC | B_ROUT | B_ZI | B_BUSY | {op, 19'd0};
  endfunction

  typedef struct {
    string       tag;
    logic [23:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Drive inputs for the coming edge, queue the word the DUT must show after it, then check.
  task automatic cyc(input string tag, input logic r, input logic [4:0] op, input logic ack,
                     input logic clr, input logic [23:0] exp_v);
    exp_t e;
    run     = r;
    opcode  = op;
    mem_ack = ack;
    clear   = clr;
    sb_q.push_back('{tag, exp_v});
    @(negedge clk);
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
    n_cmp++;
    assert ($onehot0({pco, zlo, mdro, rout})) else begin
      n_fail++;
      $error("FAIL %s_busdrv: observed %b expected at most one", e.tag,
             {pco, zlo, mdro, rout});
    end
  endtask

  // From F0 through F1 (immediate ack) and F2 into DEC.
  task automatic fetch(input string tag, input logic [4:0] op);
    cyc({tag, "_f1"}, 1'b1, op, 1'b1, 1'b0, E_F1F);
    cyc({tag, "_f2"}, 1'b1, op, 1'b1, 1'b0, E_F2);
    cyc({tag, "_dec"}, 1'b1, op, 1'b1, 1'b0, E_DEC);
  endtask

  initial begin
    clear = 1'b1; run = 1'b1; mem_ack = 1'b0; opcode = 5'd0;

    // Reset with run held high.
    cyc("rst0", 1'b1, 5'd0, 1'b0, 1'b1, E_IDLE);
    cyc("rst1", 1'b1, 5'd0, 1'b0, 1'b1, E_IDLE);

    // R-type 00011, immediate ack, then straight back into F0.
    cyc("t2_f0", 1'b1, 5'd3, 1'b1, 1'b0, E_F0);
    fetch("t2", 5'd3);
    cyc("t2_t3", 1'b1, 5'd3, 1'b1, 1'b0, E_T3);
    cyc("t2_t4", 1'b1, 5'd3, 1'b1, 1'b0, e_t4(5'd3));
    cyc("t2_t5", 1'b1, 5'd3, 1'b1, 1'b0, E_T5);
    cyc("t2_f0b", 1'b1, 5'd5, 1'b0, 1'b0, E_F0);

    // Ack delayed 3 cycles: four F1 cycles, pci only in the first; stop at T5 with run=0.
    cyc("t3_f1a", 1'b1, 5'd5, 1'b0, 1'b0, E_F1F);
    for (int i = 0; i < 3; i++) cyc("t3_f1w", 1'b1, 5'd5, 1'b0, 1'b0, E_F1W);
    cyc("t3_f2", 1'b1, 5'd5, 1'b1, 1'b0, E_F2);
    cyc("t3_dec", 1'b1, 5'd5, 1'b0, 1'b0, E_DEC);
    cyc("t3_t3", 1'b1, 5'd5, 1'b0, 1'b0, E_T3);
    cyc("t3_t4", 1'b1, 5'd5, 1'b0, 1'b0, e_t4(5'd5));
    cyc("t3_t5", 1'b1, 5'd5, 1'b0, 1'b0, E_T5);
    cyc("t3_idle", 1'b0, 5'd5, 1'b0, 1'b0, E_IDLE);

    // No ack: 16 F1 cycles, then sticky FAULT until clear.
    cyc("t4_f0", 1'b1, 5'd1, 1'b0, 1'b0, E_F0);
    cyc("t4_f1a", 1'b1, 5'd1, 1'b0, 1'b0, E_F1F);
    for (int i = 0; i < 15; i++) cyc("t4_f1w", 1'b1, 5'd1, 1'b0, 1'b0, E_F1W);
    cyc("t4_fault", 1'b1, 5'd1, 1'b0, 1'b0, E_FAULT);
    cyc("t4_stick0", 1'b0, 5'd1, 1'b1, 1'b0, E_FAULT);
    cyc("t4_stick1", 1'b1, 5'd1, 1'b1, 1'b0, E_FAULT);
    cyc("t4_clear", 1'b1, 5'd1, 1'b0, 1'b1, E_IDLE);

    // HALT is sticky regardless of run.
    cyc("t5_f0", 1'b1, 5'd27, 1'b0, 1'b0, E_F0);
    fetch("t5", 5'd27);
    cyc("t5_halt", 1'b1, 5'd27, 1'b0, 1'b0, E_HALT);
    cyc("t5_run0", 1'b0, 5'd27, 1'b0, 1'b0, E_HALT);
    cyc("t5_run1", 1'b1, 5'd27, 1'b0, 1'b0, E_HALT);
    cyc("t5_clear", 1'b0, 5'd27, 1'b0, 1'b1, E_IDLE);

    // Illegal opcode 11111.
    cyc("ill_f0", 1'b1, 5'd31, 1'b0, 1'b0, E_F0);
    fetch("ill", 5'd31);
    cyc("ill_fault", 1'b1, 5'd31, 1'b0, 1'b0, E_FAULT);
    cyc("ill_clear", 1'b0, 5'd31, 1'b0, 1'b1, E_IDLE);

    // NOP with run=1 refetches; NOP with run=0 returns to IDLE.
    cyc("nop_f0", 1'b1, 5'd24, 1'b0, 1'b0, E_F0);
    fetch("nop1", 5'd24);
    cyc("nop_f0b", 1'b1, 5'd24, 1'b0, 1'b0, E_F0);
    fetch("nop2", 5'd24);
    cyc("nop_idle", 1'b0, 5'd24, 1'b0, 1'b0, E_IDLE);

    // Clear during T4 of opcode 01011 (top of ALU range).
    cyc("t6_f0", 1'b1, 5'd11, 1'b0, 1'b0, E_F0);
    fetch("t6", 5'd11);
    cyc("t6_t3", 1'b1, 5'd11, 1'b0, 1'b0, E_T3);
    cyc("t6_t4", 1'b1, 5'd11, 1'b0, 1'b0, e_t4(5'd11));
    cyc("t6_clr", 1'b1, 5'd11, 1'b0, 1'b1, E_IDLE);

    // run dropped during T3 of opcode 00000: instruction completes, then IDLE.
    cyc("t6b_f0", 1'b1, 5'd0, 1'b0, 1'b0, E_F0);
    fetch("t6b", 5'd0);
    cyc("t6b_t3", 1'b1, 5'd0, 1'b0, 1'b0, E_T3);
    cyc("t6b_t4", 1'b0, 5'd0, 1'b0, 1'b0, e_t4(5'd0));
    cyc("t6b_t5", 1'b0, 5'd0, 1'b0, 1'b0, E_T5);
    cyc("t6b_idle", 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    cyc("t6b_stay", 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);

    // Opcode 01100 is just past the ALU range.
    cyc("bnd_f0", 1'b1, 5'd12, 1'b0, 1'b0, E_F0);
    fetch("bnd", 5'd12);
    cyc("bnd_fault", 1'b1, 5'd12, 1'b0, 1'b0, E_FAULT);
    cyc("bnd_clear", 1'b0, 5'd12, 1'b0, 1'b1, E_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
